capture_controller: RTL and testbench

Sequences one acquisition of the logic analyzer around the channel trigger. On `start` it pulses `arm` to the trigger and records `dataIn` into an internal circular sample buffer while waiting. When the trigger raises `run`, it captures a programmable number of post-trigger samples, then streams the whole buffer out oldest-first over a valid/ready port to the host link.

---
 rtl/la_pkg.sv | 15 +
 rtl/capture_controller_if.sv | 12 +
 rtl/capture_controller_ram.sv | 28 ++
 rtl/capture_controller.sv | 191 +++++++++++++++++++
 tb/tb_capture_controller.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/la_pkg.sv
// Shared logic-analyzer definitions: sample width and capture sequencer states.
package la_pkg;

  localparam int unsigned SAMPLE_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT_TRIG,
    POST,
    READOUT,
    DONE
  } cap_state_t;

endpackage

// File: rtl/capture_controller_if.sv
// Readout stream from the capture controller to the host link (valid/ready).
interface capture_controller_if;

  logic [la_pkg::SAMPLE_WIDTH-1:0] rdData;
  logic                            rdValid;
  logic                            rdReady;
  logic                            rdLast;

  modport master (output rdData, output rdValid, output rdLast, input rdReady);
  modport slave  (input rdData, input rdValid, input rdLast, output rdReady);

endinterface

// File: rtl/capture_controller_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
module capture_ram
  import la_pkg::*;
#(
  parameter  int unsigned DEPTH  = 1024,
  parameter  int unsigned WIDTH  = SAMPLE_WIDTH,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clock) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/capture_controller.sv
// Acquisition sequencer: arms the trigger, fills a circular buffer around the
// trigger point, then streams the buffer out oldest-first.
module capture_controller
  import la_pkg::*;
#(
  parameter  int unsigned DEPTH  = 1024,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic [ADDR_W-1:0]       postCount,
  input  logic [SAMPLE_WIDTH-1:0] dataIn,
  input  logic                    run,
  output logic                    arm,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_W-1:0]       trigAddr,
  capture_controller_if.master    rd
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  cap_state_t state_q, state_nx;

  logic [ADDR_W-1:0] wr_ptr_q, post_len_q, post_cnt_q;
  logic              wrapped_q;
  logic [CNT_W-1:0]  rd_idx_q, rd_len_c;
  logic [ADDR_W-1:0] rd_base_c, rd_addr_c;
  logic              wr_en_c, start_ok_c, trig_c, rd_issue_c, issue_last_c, fire_c;
  logic [1:0]        occ_c;

  logic                    ram_vld_q, ram_last_q;
  logic                    skid_vld_q, skid_last_q;
  logic                    out_vld_q, out_last_q;
  logic [SAMPLE_WIDTH-1:0] ram_rdata, skid_data_q, out_data_q;

  // Before the first wrap the write pointer equals the number of samples written.
  assign rd_base_c    = wrapped_q ? wr_ptr_q : '0;
  assign rd_len_c     = wrapped_q ? CNT_W'(DEPTH) : {1'b0, wr_ptr_q};
  assign rd_addr_c    = rd_base_c + rd_idx_q[ADDR_W-1:0];
  assign issue_last_c = (rd_idx_q == rd_len_c - CNT_W'(1));
  assign fire_c       = out_vld_q && rd.rdReady;
  // Words held or in flight after this edge; a new read needs one free slot.
  assign occ_c        = 2'(out_vld_q) + 2'(skid_vld_q) + 2'(ram_vld_q) - 2'(fire_c);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_nx;
  end

  always_comb begin
    state_nx   = state_q;
    wr_en_c    = 1'b0;
    start_ok_c = 1'b0;
    trig_c     = 1'b0;
    rd_issue_c = 1'b0;
    if (abort) begin
      state_nx = IDLE;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            start_ok_c = 1'b1;
            state_nx   = ARM;
          end
        end
        ARM: begin
          wr_en_c  = 1'b1;
          state_nx = WAIT_TRIG;
        end
        WAIT_TRIG: begin
          wr_en_c = 1'b1;
          if (run) begin
            trig_c   = 1'b1;
            state_nx = (post_len_q == '0) ? READOUT : POST;
          end
        end
        POST: begin
          wr_en_c = 1'b1;
          if (post_cnt_q == ADDR_W'(1)) state_nx = READOUT;
        end
        READOUT: begin
          rd_issue_c = (rd_idx_q != rd_len_c) && (occ_c <= 2'd1);
          if (fire_c && out_last_q) state_nx = DONE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      arm  <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      arm  <= (state_nx == ARM);
      busy <= (state_nx != IDLE);
      done <= (state_nx == READOUT) || (state_nx == DONE);
    end
  end

  // Write pointer, wrap flag, trigger address and post-trigger countdown.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      wrapped_q  <= 1'b0;
      post_len_q <= '0;
      post_cnt_q <= '0;
      trigAddr   <= '0;
      rd_idx_q   <= '0;
    end else begin
      if (start_ok_c) begin
        wr_ptr_q   <= '0;
        wrapped_q  <= 1'b0;
        post_len_q <= postCount;
        rd_idx_q   <= '0;
      end
      if (wr_en_c) begin
        wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
        if (wr_ptr_q == ADDR_W'(DEPTH - 1)) wrapped_q <= 1'b1;
      end
      if (trig_c) begin
        trigAddr   <= wr_ptr_q;
        post_cnt_q <= post_len_q;
      end else if (wr_en_c && state_q == POST) begin
        post_cnt_q <= post_cnt_q - ADDR_W'(1);
      end
      if (rd_issue_c) rd_idx_q <= rd_idx_q + CNT_W'(1);
    end
  end

  capture_ram #(.DEPTH(DEPTH), .WIDTH(SAMPLE_WIDTH)) u_ram (
    .clock   (clock),
    .wr_en   (wr_en_c),
    .wr_addr (wr_ptr_q),
    .wr_data (dataIn),
    .rd_en   (rd_issue_c),
    .rd_addr (rd_addr_c),
    .rd_data (ram_rdata)
  );

  // Output register plus skid slot: absorbs the read in flight when the sink stalls.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ram_vld_q   <= 1'b0;
      ram_last_q  <= 1'b0;
      skid_vld_q  <= 1'b0;
      skid_last_q <= 1'b0;
      skid_data_q <= '0;
      out_vld_q   <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else if (abort) begin
      ram_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
    end else begin
      ram_vld_q <= rd_issue_c;
      if (rd_issue_c) ram_last_q <= issue_last_c;
      if (!out_vld_q || fire_c) begin
        if (skid_vld_q) begin
          out_vld_q  <= 1'b1;
          out_data_q <= skid_data_q;
          out_last_q <= skid_last_q;
          skid_vld_q <= ram_vld_q;
          if (ram_vld_q) begin
            skid_data_q <= ram_rdata;
            skid_last_q <= ram_last_q;
          end
        end else begin
          out_vld_q  <= ram_vld_q;
          out_last_q <= ram_vld_q && ram_last_q;
          if (ram_vld_q) out_data_q <= ram_rdata;
        end
      end else if (ram_vld_q) begin
        skid_vld_q  <= 1'b1;
        skid_data_q <= ram_rdata;
        skid_last_q <= ram_last_q;
      end
    end
  end

  assign rd.rdData  = out_data_q;
  assign rd.rdValid = out_vld_q;
  assign rd.rdLast  = out_last_q;

endmodule

// File: tb/tb_capture_controller.sv
// Scoreboard bench for capture_controller at DEPTH=16.
module tb_capture_controller;
  import la_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  typedef struct packed {
    logic [SAMPLE_WIDTH-1:0] data;
    logic                    last;
  } beat_t;

  logic                    clock = 1'b0;
  logic                    reset = 1'b0;
  logic                    start = 1'b0;
  logic                    abort = 1'b0;
  logic                    run   = 1'b0;
  logic [AW-1:0]           postCount = '0;
  logic [SAMPLE_WIDTH-1:0] dataIn = '0;
  logic                    arm, busy, done;
  logic [AW-1:0]           trigAddr;

  capture_controller_if rd_if ();

  capture_controller #(.DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .postCount (postCount),
    .dataIn    (dataIn),
    .run       (run),
    .arm       (arm),
    .busy      (busy),
    .done      (done),
    .trigAddr  (trigAddr),
    .rd        (rd_if.master)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  beat_t                   exp_q[$];
  logic [SAMPLE_WIDTH-1:0] written[$];
  logic [SAMPLE_WIDTH-1:0] got[$];

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Drives one acquisition up to READOUT entry (or an abort in POST) and
  // queues the expected readout: the newest min(n, DEPTH) samples in order.
  task automatic acquire(input int k, input int p, input bit inj, input int abort_post);
    int v;
    int n;
    int first;
    v = 0;
    written.delete();
    start = 1'b1; postCount = AW'(p); tick; start = 1'b0;
    n_vec++;
    if (arm !== 1'b1 || busy !== 1'b1) begin
      n_err++; $display("FAIL arm_pulse: arm=%b busy=%b, required 1 1", arm, busy);
    end
    dataIn = SAMPLE_WIDTH'(v); written.push_back(dataIn); v++; tick;
    for (int i = 1; i <= k; i++) begin
      dataIn = SAMPLE_WIDTH'(v); written.push_back(dataIn); v++;
      run   = (i == k);
      start = inj && (i == 2);
      tick;
      run = 1'b0; start = 1'b0;
      n_vec++;
      if (arm !== 1'b0) begin
        n_err++; $display("FAIL arm_stray: wait cycle %0d arm=%b, required 0", i, arm);
      end
    end
    n_vec++;
    if (trigAddr !== AW'(k)) begin
      n_err++; $display("FAIL trig_addr: got %0d, required %0d", trigAddr, AW'(k));
    end
    for (int j = 1; j <= p; j++) begin
      if (j == abort_post) begin
        abort = 1'b1; tick; abort = 1'b0;
        n_vec++;
        if ({busy, done, arm, rd_if.rdValid} !== 4'b0000 || trigAddr !== AW'(k)) begin
          n_err++;
          $display("FAIL abort: busy=%b done=%b arm=%b valid=%b trig=%0d, required 0 0 0 0 %0d",
                   busy, done, arm, rd_if.rdValid, trigAddr, AW'(k));
        end
        written.delete();
        return;
      end
      dataIn = SAMPLE_WIDTH'(v); written.push_back(dataIn); v++; tick;
    end
    n_vec++;
    if (done !== 1'b1 || busy !== 1'b1 || rd_if.rdValid !== 1'b0) begin
      n_err++;
      $display("FAIL readout_entry: done=%b busy=%b valid=%b, required 1 1 0", done, busy, rd_if.rdValid);
    end
    n = written.size();
    first = (n > int'(DEPTH)) ? n - int'(DEPTH) : 0;
    for (int idx = first; idx < n; idx++) exp_q.push_back('{data: written[idx], last: (idx == n - 1)});
  endtask

  task automatic readout(input bit rand_ready);
    int c;
    int first_c;
    bit held;
    logic [SAMPLE_WIDTH-1:0] hd;
    logic hl;
    beat_t e;
    c = 0; first_c = -1; held = 1'b0; hd = '0; hl = 1'b0;
    got.delete();
    while (exp_q.size() > 0 && c < 300) begin
      if (held) begin
        n_vec++;
        if (rd_if.rdData !== hd || rd_if.rdLast !== hl) begin
          n_err++;
          $display("FAIL stall_hold: data=%0d last=%b, required %0d %b", rd_if.rdData, rd_if.rdLast, hd, hl);
        end
      end
      if (rd_if.rdValid && first_c < 0) first_c = c;
      rd_if.rdReady = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rd_if.rdValid && rd_if.rdReady) begin
        e = exp_q.pop_front();
        got.push_back(rd_if.rdData);
        n_vec++;
        if (rd_if.rdData !== e.data || rd_if.rdLast !== e.last) begin
          n_err++;
          $display("FAIL beat %0d: data=%0d last=%b, required %0d %b",
                   got.size(), rd_if.rdData, rd_if.rdLast, e.data, e.last);
        end
      end
      held = rd_if.rdValid && !rd_if.rdReady;
      hd   = rd_if.rdData;
      hl   = rd_if.rdLast;
      tick; c++;
    end
    rd_if.rdReady = 1'b0;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL readout_timeout: %0d beats outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    if (!rand_ready) begin
      n_vec++;
      if (first_c != 2 || c != got.size() + 2) begin
        n_err++;
        $display("FAIL readout_rate: first valid cycle %0d, cycles %0d, required 2 and %0d",
                 first_c, c, got.size() + 2);
      end
    end
    n_vec++;
    if (done !== 1'b1 || busy !== 1'b1 || rd_if.rdValid !== 1'b0 || arm !== 1'b0) begin
      n_err++;
      $display("FAIL done_state: done=%b busy=%b valid=%b arm=%b, required 1 1 0 0",
               done, busy, rd_if.rdValid, arm);
    end
  endtask

  task automatic test_reset;
    #1 reset = 1'b1;
    #2;
    n_vec++;
    if ({arm, busy, done, rd_if.rdValid, rd_if.rdLast} !== 5'b0 || trigAddr !== '0 || rd_if.rdData !== '0) begin
      n_err++;
      $display("FAIL reset_values: arm=%b busy=%b done=%b valid=%b last=%b trig=%0d data=%0d, required all 0",
               arm, busy, done, rd_if.rdValid, rd_if.rdLast, trigAddr, rd_if.rdData);
    end
    tick; tick;
    reset = 1'b0;
    tick;
  endtask

  task automatic test_no_wrap;
    acquire(5, 3, 1'b0, 0);
    readout(1'b0);
    n_vec++;
    if (got.size() != 9) begin
      n_err++; $display("FAIL no_wrap_len: %0d beats, required 9", got.size());
    end
  endtask

  task automatic test_min_post;
    acquire(1, 0, 1'b0, 0);
    readout(1'b0);
    n_vec++;
    if (got.size() != 2) begin
      n_err++; $display("FAIL min_post_len: %0d beats, required 2", got.size());
    end
  endtask

  task automatic test_wrap;
    acquire(41, 4, 1'b0, 0);
    readout(1'b1);
    n_vec++;
    if (got.size() != 16 || got[11] !== SAMPLE_WIDTH'(41) || got[15] !== SAMPLE_WIDTH'(45)) begin
      n_err++;
      $display("FAIL wrap_window: %0d beats, beat12=%0d, beat16=%0d, required 16 41 45",
               got.size(), got[11], got[got.size() - 1]);
    end
  endtask

  task automatic test_stall_random;
    acquire(7, 2, 1'b0, 0);
    readout(1'b1);
  endtask

  task automatic test_start_ignored;
    acquire(6, 2, 1'b1, 0);
    readout(1'b0);
  endtask

  task automatic test_abort;
    acquire(3, 5, 1'b0, 2);
    acquire(4, 2, 1'b0, 0);
    readout(1'b0);
  endtask

  task automatic test_reset_mid_readout;
    acquire(3, 3, 1'b0, 0);
    rd_if.rdReady = 1'b0;
    tick; tick;
    n_vec++;
    if (rd_if.rdValid !== 1'b1) begin
      n_err++; $display("FAIL pre_reset_valid: valid=%b, required 1", rd_if.rdValid);
    end
    #3 reset = 1'b1;
    #1;
    n_vec++;
    if ({rd_if.rdValid, done, busy, arm, rd_if.rdLast} !== 5'b0 || trigAddr !== '0 || rd_if.rdData !== '0) begin
      n_err++;
      $display("FAIL async_reset: valid=%b done=%b busy=%b arm=%b last=%b trig=%0d, required all 0",
               rd_if.rdValid, done, busy, arm, rd_if.rdLast, trigAddr);
    end
    exp_q.delete();
    tick;
    reset = 1'b0;
    tick;
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL post_reset_idle: busy=%b, required 0", busy);
    end
    acquire(2, 1, 1'b0, 0);
    readout(1'b0);
  endtask

  initial begin
    rd_if.rdReady = 1'b0;
    test_reset();
    test_no_wrap();
    test_min_post();
    test_wrap();
    test_stall_random();
    test_start_ignored();
    test_abort();
    test_reset_mid_readout();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
